// File: rtl/sdram_slot_req.sv
// sdram_slot_req: per-slot SDRAM request front-end with a small line cache for one client.
module sdram_slot_req #(
    parameter int SDRAMW  = 22,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RW      = 0,
    parameter int LATCH   = 0,
    parameter int DOUBLE  = 0,
    parameter int OKLATCH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [SDRAMW-1:0] offset,
    input  logic [AW-1:0]     addr,
    input  logic              addr_ok,
    input  logic [DW-1:0]     wrdata,
    input  logic              wrin,
    output logic              req_rnw,
    output logic [SDRAMW-1:0] sdram_addr,
    input  logic [15:0]       din,
    input  logic              din_ok,
    input  logic              dst,
    output logic [DW-1:0]     dout,
    output logic              req,
    output logic              data_ok,
    input  logic              we
);
    localparam int N = (RW == 0 && DOUBLE != 0) ? 2 : 1;

    logic [SDRAMW-1:0] wa;
    logic [SDRAMW-1:0] tag_q [N];
    logic [15:0]       w0_q [N];
    logic [15:0]       w1_q [N];
    logic [N-1:0]      valid_q, match;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     dout_q, dout_c;
    logic [31:0]       line;
    logic ptr_q, wait_q, cs_q, req_q, rnw_q, ram_ok_q, ok_q, lok_q;
    logic hit, stable, start, take, sel, fi, ok1, unused_wr;

    assign wa = DW == 8  ? SDRAMW'(addr[AW-1:1]) :
                DW == 16 ? SDRAMW'(addr) : SDRAMW'({addr, 1'b0});
    assign sdram_addr = offset + wa;

    for (genvar i = 0; i < N; i++) begin : g_match
        assign match[i] = valid_q[i] && tag_q[i] == wa;
    end

    assign fi     = (N == 2) ? ptr_q : 1'b0;
    assign sel    = (N == 2) ? match[N-1] : 1'b0;
    assign take   = we & din_ok;
    assign stable = addr_ok && addr == addr_q;
    assign start  = addr_ok && (!cs_q || addr != addr_q);
    assign hit    = (RW != 0) ? ram_ok_q : addr_ok & |match;
    assign line   = {w1_q[sel], w0_q[sel]};
    assign dout_c = DW'(DW == 8  ? {24'd0, addr[0] ? line[15:8] : line[7:0]} :
                        DW == 16 ? {16'd0, line[15:0]} : line);
    // Registered ok is qualified by an unchanged address so stale data is never flagged.
    assign ok1     = (RW != 0) ? ram_ok_q & stable : (OKLATCH != 0) ? ok_q & stable : hit;
    assign data_ok = ~rst & ((LATCH != 0) ? lok_q & stable : ok1);
    assign req     = ~rst & ((RW != 0) ? req_q : addr_ok & ~hit);
    assign dout    = (LATCH != 0) ? dout_q : dout_c;
    assign req_rnw = (RW != 0) ? rnw_q : 1'b1;
    assign unused_wr = ^wrdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            ptr_q    <= 1'b0;
            wait_q   <= 1'b0;
            cs_q     <= 1'b0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            rnw_q    <= 1'b1;
            ram_ok_q <= 1'b0;
            ok_q     <= 1'b0;
            lok_q    <= 1'b0;
            dout_q   <= '0;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= '0;
                w0_q[i]  <= '0;
                w1_q[i]  <= '0;
            end
        end else begin
            cs_q   <= addr_ok;
            addr_q <= addr;
            ok_q   <= hit;
            lok_q  <= ok1;
            dout_q <= dout_c;
            if (RW != 0) begin
                if (start) begin
                    req_q    <= 1'b1;
                    rnw_q    <= ~wrin;
                    ram_ok_q <= 1'b0;
                end else if (req_q && take) begin
                    req_q    <= 1'b0;
                    ram_ok_q <= 1'b1;
                    if (rnw_q) w0_q[0] <= din;
                end else if (!addr_ok) begin
                    ram_ok_q <= 1'b0;
                end
            end else begin
                // An entry only becomes valid once its last word has landed.
                if (take && dst) begin
                    tag_q[fi]   <= wa;
                    w0_q[fi]    <= din;
                    valid_q[fi] <= DW != 32;
                    wait_q      <= DW == 32;
                    if (DW != 32) ptr_q <= ~ptr_q;
                end else if (take && wait_q) begin
                    w1_q[fi]    <= din;
                    valid_q[fi] <= 1'b1;
                    wait_q      <= 1'b0;
                    ptr_q       <= ~ptr_q;
                end
                if (clr) begin
                    valid_q <= '0;
                    wait_q  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_slot_req.sv
// tb_sdram_slot_req: scoreboard bench over four slot configurations (ROM8, ROM32, ROM8 double, RAM8).
module tb_sdram_slot_req;
    localparam int F_REQ = 0, F_OK = 1, F_DO = 2, F_SA = 3, F_RN = 4;

    typedef struct { int k; int f; logic [31:0] v; } probe_t;
    typedef struct { int k; logic [31:0] v; bit care; } dexp_t;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, din_ok = 1'b0, dst = 1'b0, wrin = 1'b0;
    logic [21:0] offset = 22'h100;
    logic [15:0] din = '0;
    logic [7:0]  wrd8 = '0;
    logic [31:0] wrd32 = '0;
    logic [7:0]  addr_s [4];
    logic        cs_s [4], we_s [4];
    logic        req_w [4], ok_w [4], rnw_w [4], prev_ok [4];
    logic [21:0] sa_w [4];
    logic [7:0]  dout0, dout2, dout3;
    logic [31:0] dout1;

    probe_t pq[$];
    dexp_t  dq[$];
    bit     done = 1'b0;
    int     cyc = 0, checks = 0, fails = 0;
    string  fn [5] = '{"req", "data_ok", "dout", "sdram_addr", "req_rnw"};

    always #5 clk = ~clk;

    sdram_slot_req #(.DW(8)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_s[0]), .addr_ok(cs_s[0]),
        .wrdata(wrd8), .wrin(wrin), .req_rnw(rnw_w[0]), .sdram_addr(sa_w[0]), .din(din),
        .din_ok(din_ok), .dst(dst), .dout(dout0), .req(req_w[0]), .data_ok(ok_w[0]), .we(we_s[0]));
    sdram_slot_req #(.DW(32)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_s[1]), .addr_ok(cs_s[1]),
        .wrdata(wrd32), .wrin(wrin), .req_rnw(rnw_w[1]), .sdram_addr(sa_w[1]), .din(din),
        .din_ok(din_ok), .dst(dst), .dout(dout1), .req(req_w[1]), .data_ok(ok_w[1]), .we(we_s[1]));
    sdram_slot_req #(.DW(8), .DOUBLE(1), .OKLATCH(0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_s[2]), .addr_ok(cs_s[2]),
        .wrdata(wrd8), .wrin(wrin), .req_rnw(rnw_w[2]), .sdram_addr(sa_w[2]), .din(din),
        .din_ok(din_ok), .dst(dst), .dout(dout2), .req(req_w[2]), .data_ok(ok_w[2]), .we(we_s[2]));
    sdram_slot_req #(.DW(8), .RW(1)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr_s[3]), .addr_ok(cs_s[3]),
        .wrdata(wrd8), .wrin(wrin), .req_rnw(rnw_w[3]), .sdram_addr(sa_w[3]), .din(din),
        .din_ok(din_ok), .dst(dst), .dout(dout3), .req(req_w[3]), .data_ok(ok_w[3]), .we(we_s[3]));

    function automatic logic [31:0] obs(int k, int f);
        logic [31:0] d;
        d = k == 0 ? 32'(dout0) : k == 1 ? dout1 : k == 2 ? 32'(dout2) : 32'(dout3);
        case (f)
            F_REQ:   return 32'(req_w[k]);
            F_OK:    return 32'(ok_w[k]);
            F_DO:    return d;
            F_SA:    return 32'(sa_w[k]);
            default: return 32'(rnw_w[k]);
        endcase
    endfunction

    // Monitor: applies pending probes and pops a data expectation on every data_ok rise.
    always @(negedge clk) begin
        while (pq.size() > 0) begin
            probe_t p;
            p = pq.pop_front();
            checks++;
            if (obs(p.k, p.f) !== p.v) begin
                fails++;
                $display("FAIL dut%0d %s: got %h, expected %h", p.k, fn[p.f], obs(p.k, p.f), p.v);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (ok_w[k] === 1'b1 && prev_ok[k] !== 1'b1) begin
                checks++;
                if (dq.size() == 0 || dq[0].k != k) begin
                    fails++;
                    $display("FAIL dut%0d data_ok rise: dout %h arrived with no matching expectation", k, obs(k, F_DO));
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    if (e.care && obs(k, F_DO) !== e.v) begin
                        fails++;
                        $display("FAIL dut%0d read data: got %h, expected %h", k, obs(k, F_DO), e.v);
                    end
                end
            end
            prev_ok[k] = ok_w[k];
        end
        cyc++;
        if (done || cyc > 3000) begin
            checks++;
            if (!done) begin
                fails++;
                $display("FAIL timeout: cycle %0d reached, stimulus expected to end first", cyc);
            end
            checks++;
            if (dq.size() != 0) begin
                fails++;
                $display("FAIL pending data_ok: got %0d unconsumed expectations, expected 0", dq.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(int k, int f, logic [31:0] v);
        pq.push_back(probe_t'{k, f, v});
    endtask

    task automatic exd(int k, logic [31:0] v, bit care);
        dq.push_back(dexp_t'{k, v, care});
    endtask

    task automatic fill(int k, logic [15:0] d, logic s);
        we_s[k] = 1'b1;
        din_ok  = 1'b1;
        dst     = s;
        din     = d;
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) we_s[i] = 1'b0;
        din_ok = 1'b0;
        dst    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr_s[i] = '0; cs_s[i] = 1'b0; we_s[i] = 1'b0; prev_ok[i] = 1'b0;
        end
        tick(); tick();
        ex(0, F_REQ, 0); ex(0, F_OK, 0); ex(0, F_DO, 0); ex(0, F_RN, 1);
        ex(1, F_DO, 0); ex(3, F_REQ, 0); ex(3, F_RN, 1);
        tick();
        rst = 1'b0; tick();
        // ROM DW=8 miss, fill, then same-line hit
        addr_s[0] = 8'h05; cs_s[0] = 1'b1;
        ex(0, F_SA, 32'h102); ex(0, F_REQ, 1); ex(0, F_OK, 0); tick();
        fill(0, 16'hABCD, 1'b1); exd(0, 32'hAB, 1'b1); tick();
        idle(); ex(0, F_REQ, 0); ex(0, F_DO, 32'hAB); ex(0, F_OK, 0); tick();
        ex(0, F_OK, 1); tick();
        addr_s[0] = 8'h04; exd(0, 32'hCD, 1'b1);
        ex(0, F_OK, 0); ex(0, F_REQ, 0); ex(0, F_DO, 32'hCD); tick();
        ex(0, F_OK, 1); tick();
        cs_s[0] = 1'b0; ex(0, F_OK, 0); tick();
        // ROM DW=32 two-word line
        addr_s[1] = 8'h03; cs_s[1] = 1'b1; ex(1, F_SA, 32'h106); ex(1, F_REQ, 1); tick();
        fill(1, 16'h1111, 1'b1); tick();
        fill(1, 16'h2222, 1'b0); ex(1, F_REQ, 1); ex(1, F_OK, 0); exd(1, 32'h22221111, 1'b1); tick();
        idle(); ex(1, F_REQ, 0); ex(1, F_DO, 32'h22221111); ex(1, F_OK, 0); tick();
        ex(1, F_OK, 1); tick();
        cs_s[1] = 1'b0; tick();
        // ROM DOUBLE with combinational data_ok, then clr
        addr_s[2] = 8'h20; cs_s[2] = 1'b1; ex(2, F_REQ, 1); ex(2, F_SA, 32'h110); tick();
        fill(2, 16'h1234, 1'b1); exd(2, 32'h34, 1'b1); tick();
        idle(); ex(2, F_REQ, 0); ex(2, F_OK, 1); tick();
        addr_s[2] = 8'h41; ex(2, F_REQ, 1); ex(2, F_OK, 0); tick();
        fill(2, 16'h5678, 1'b1); exd(2, 32'h56, 1'b1); tick();
        idle(); ex(2, F_REQ, 0); ex(2, F_OK, 1); ex(2, F_DO, 32'h56); tick();
        addr_s[2] = 8'h20; ex(2, F_REQ, 0); ex(2, F_OK, 1); ex(2, F_DO, 32'h34); tick();
        clr = 1'b1; tick();
        clr = 1'b0; ex(2, F_REQ, 1); ex(2, F_OK, 0); tick();
        cs_s[2] = 1'b0; tick();
        // RAM write then read
        addr_s[3] = 8'h10; cs_s[3] = 1'b1; wrin = 1'b1; wrd8 = 8'h5A; ex(3, F_REQ, 0); tick();
        ex(3, F_REQ, 1); ex(3, F_RN, 0); ex(3, F_SA, 32'h108); ex(3, F_OK, 0); tick();
        fill(3, 16'h0000, 1'b0); exd(3, 32'h0, 1'b0); tick();
        idle(); ex(3, F_REQ, 0); ex(3, F_OK, 1); tick();
        ex(3, F_OK, 1); tick();
        cs_s[3] = 1'b0; wrin = 1'b0; ex(3, F_OK, 0); tick();
        addr_s[3] = 8'h11; cs_s[3] = 1'b1; tick();
        ex(3, F_REQ, 1); ex(3, F_RN, 1); tick();
        fill(3, 16'hBEEF, 1'b0); exd(3, 32'hBE, 1'b1); tick();
        idle(); ex(3, F_REQ, 0); ex(3, F_OK, 1); ex(3, F_DO, 32'hBE); tick();
        cs_s[3] = 1'b0; ex(3, F_OK, 0); tick();
        // Reset during a pending fill invalidates a previously hitting line
        addr_s[0] = 8'h09; cs_s[0] = 1'b1; ex(0, F_REQ, 1); tick();
        fill(0, 16'h7788, 1'b1); exd(0, 32'h77, 1'b1); tick();
        idle(); ex(0, F_REQ, 0); tick();
        ex(0, F_OK, 1); ex(0, F_DO, 32'h77); tick();
        addr_s[0] = 8'h0C; ex(0, F_REQ, 1); ex(0, F_OK, 0); tick();
        rst = 1'b1; fill(0, 16'h9999, 1'b1); tick();
        idle(); ex(0, F_REQ, 0); ex(0, F_OK, 0); ex(0, F_DO, 0); tick();
        rst = 1'b0; addr_s[0] = 8'h09; ex(0, F_REQ, 1); ex(0, F_OK, 0); ex(0, F_DO, 0); tick();
        cs_s[0] = 1'b0; tick();
        done = 1'b1;
        tick();
    end
endmodule

// File: doc/sdram_slot_req.md
Name: sdram_slot_req

Overview:
- Per-slot SDRAM request front-end. It sits between one client (CPU or video fetcher) and the shared slot arbiter/SDRAM controller.
- Translates a client address into an SDRAM word address, raises a request and captures the returned 16-bit words. It serves client reads from a small cache and reports completion through data_ok.
- RW=0 gives a read-only ROM slot with a persistent cache. RW=1 gives a read/write RAM slot with no persistent cache.

Parameters:
- SDRAMW, 22, SDRAM word-address width.
- AW, 8, client address width.
- DW, 8, client data width; legal values are 8, 16 and 32.
- RW, 0, 0 = ROM slot, 1 = RAM slot (writes enabled).
- LATCH, 0, 1 = dout registered (one extra cycle); 0 = dout combinational from the cache.
- DOUBLE, 0, ROM only; 1 = two cache entries, 0 = one entry.
- OKLATCH, 1, 1 = data_ok registered; 0 = data_ok combinational.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- clr, in, 1, invalidate all cache entries (ROM only; ignored when RW=1).
- offset, in, SDRAMW, base word address added to the client address.
- addr, in, AW, client address in DW-sized units.
- addr_ok, in, 1, client chip select (request valid).
- wrdata, in, DW, write data (RW=1 only).
- wrin, in, 1, write strobe qualified by addr_ok (RW=1 only).
- req_rnw, out, 1, 1 = read, 0 = write; constant 1 when RW=0.
- sdram_addr, out, SDRAMW, word address for the controller.
- din, in, 16, SDRAM read data.
- din_ok, in, 1, SDRAM data-valid strobe.
- dst, in, 1, first word of a burst.
- dout, out, DW, data to the client.
- req, out, 1, request to the arbiter.
- data_ok, out, 1, transaction complete / data valid.
- we, in, 1, arbiter has selected this slot; high from acceptance until the last din_ok.

Behaviour:
- Word address (WA): DW=8 uses addr[AW-1:1]; DW=16 uses addr; DW=32 uses {addr,1'b0}. Both forms are zero-extended.
- sdram_addr = offset + WA, modulo 2^SDRAMW, combinational.
- Line size: 16 bits when DW is 8 or 16; 32 bits (two words) when DW is 32.
- Tag = WA.
- ROM mode (RW=0):
  - Hit = addr_ok, AND a valid entry whose tag equals the current WA.
  - req = addr_ok & ~hit, combinational. req stays high until a fill makes the address hit.
  - Fill: when we & din_ok & dst, store din as word 0 and latch the tag from the current WA.
  - For DW=32, the next we & din_ok cycle stores word 1.
  - The entry becomes valid after its last word is stored.
  - DOUBLE=1: fills alternate between the two entries, replacing the older one.
- dout selection:
  - DW=8: addr[0]=0 gives the low byte, addr[0]=1 gives the high byte.
  - DW=16: the word.
  - DW=32: {word1, word0}.
- data_ok:
  - OKLATCH=0: data_ok = hit.
  - OKLATCH=1: data_ok is hit registered. It is cleared in the same cycle addr changes or addr_ok falls, so stale data is never flagged ok.
- clr: all entries become invalid at the next edge, and req re-asserts for the current addr.
- RAM mode (RW=1):
  - Starting a transaction: on a rising edge of addr_ok, or an addr change while addr_ok is high, req is set and the transaction is latched.
  - Direction: req_rnw = ~wrin, sampled at transaction start.
  - req drops at the first we & din_ok. Reads capture din at that point, as for the ROM fill.
  - data_ok goes high on the following cycle and stays high while addr_ok is high and addr is unchanged.
  - When addr_ok drops, data_ok falls and the captured data is invalidated.
  - Writes complete on we & din_ok as well; the arbiter raises din_ok for writes.
- din_ok while we is low is ignored.
- A din_ok burst whose dst was missed is ignored.
- Reset: req=0, data_ok=0, dout=0, req_rnw=1, all cache entries invalid. Reset mid-transaction abandons it; the next request restarts after reset.
- LATCH=1 delays dout by one clk relative to the cache contents; data_ok is aligned to that delayed dout.

Test Plan:
- ROM miss, DW=8, offset=0x100, addr=0x05, cs=1 -> sdram_addr=0x102, req=1. Then we=1 and din_ok=dst=1 with din=0xABCD -> req=0, data_ok=1, dout=0xAB.
- Same line hit: addr=0x04 with no new din -> req stays 0, dout=0xCD, data_ok=1 (one cycle later when OKLATCH=1).
- DW=32, addr=0x03 -> sdram_addr=offset+6. Words 0x1111 (with dst) then 0x2222 -> dout=0x22221111, data_ok only after the second word.
- DOUBLE=1: fill addresses A then B, then re-read A -> no req. Pulse clr -> req=1 for the current address.
- RAM write, RW=1: cs=1, wrin=1, addr=0x10 -> req=1, req_rnw=0; we+din_ok -> req=0, data_ok=1. Drop cs -> data_ok=0.
- Assert rst during a pending fill -> req=0, data_ok=0, dout=0, cache invalid. A later hit-address access reissues req.
